// File: rtl/sc_dmem_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a shared single-port data memory / I-O bus.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise fixed CPU priority.
module sc_dmem_arbiter #(
   parameter int IO_BIT     = 7,
   parameter int STARVE_MAX = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_ack,
   output logic        dma_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA, DONE} state_t;

   localparam logic [31:0] STARVE_LIM = STARVE_MAX;

   state_t      state_q;
   logic [2:0]  starve_q;
   logic        cpu_ack_q, dma_ack_q, dma_err_q, busy_q;
   logic [31:0] cpu_rdata_q, dma_rdata_q;
   logic        pick_dma_d;
   logic        dma_illegal;
`ifdef ARB_ROUND_ROBIN_EN
   logic        last_dma_q;
   // No grant since reset yet: the CPU takes the first tie even though last-grant resets to CPU.
   logic        rr_vld_q;
`endif

   assign dma_illegal = dma_addr[IO_BIT];

   always_comb begin
      pick_dma_d = 1'b0;
      if (dma_req && ({29'd0, starve_q} >= STARVE_LIM))
         pick_dma_d = 1'b1;
      else if (cpu_req && dma_req)
`ifdef ARB_ROUND_ROBIN_EN
         pick_dma_d = rr_vld_q && !last_dma_q;
`else
         pick_dma_d = 1'b0;
`endif
      else
         pick_dma_d = dma_req;
   end

   always_comb begin
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_we    = 1'b0;
      case (state_q)
         GNT_CPU: begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
         end
         GNT_DMA: begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we && !dma_illegal;
         end
         default: ;
      endcase
      // A reset landing on a grant cycle must not commit the write.
      if (reset) mem_we = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         starve_q    <= 3'd0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         dma_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         cpu_rdata_q <= 32'd0;
         dma_rdata_q <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
         last_dma_q  <= 1'b0;
         rr_vld_q    <= 1'b0;
`endif
      end else begin
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
         dma_err_q <= 1'b0;
         case (state_q)
            IDLE: if (cpu_req || dma_req) begin
               busy_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
               last_dma_q <= pick_dma_d;
               rr_vld_q   <= 1'b1;
`endif
               if (pick_dma_d) begin
                  state_q  <= GNT_DMA;
                  starve_q <= 3'd0;
               end else begin
                  state_q <= GNT_CPU;
                  if (dma_req && starve_q != 3'd7) starve_q <= starve_q + 3'd1;
               end
            end
            GNT_CPU: begin
               state_q   <= DONE;
               cpu_ack_q <= 1'b1;
               if (!cpu_we) cpu_rdata_q <= mem_rdata;
            end
            GNT_DMA: begin
               state_q   <= DONE;
               dma_ack_q <= 1'b1;
               dma_err_q <= dma_illegal;
               if (!dma_we && !dma_illegal) dma_rdata_q <= mem_rdata;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign dma_err   = dma_err_q;
   assign busy      = busy_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Scoreboard bench for sc_dmem_arbiter with a behavioural 256-word memory on the shared port.
module tb_sc_dmem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] dma_addr = '0, dma_wdata = '0;
   logic [31:0] dma_rdata;
   logic        dma_ack, dma_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic        busy;

   logic [31:0] mem [0:255];

   typedef struct {
      bit          dma;
      bit          err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   bit   gnt_q[$];
   int   errors = 0;
   int   checks = 0;

   sc_dmem_arbiter #(.IO_BIT(7), .STARVE_MAX(4)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clock = ~clock;

   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clock) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

   task automatic do_access(input bit dma, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit exp_err,
                            input logic [31:0] exp_rd, input string nm);
      exp_t        e;
      int          cyc, nwe;
      logic [31:0] gaddr, rd;
      bit          got;
      sb.push_back('{dma: dma, err: exp_err, rdata: exp_rd});
      if (dma) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      cyc = 0; nwe = 0; gaddr = '0; got = 1'b0;
      while (!got && cyc < 10) begin
         @(posedge clock); #1;
         cyc++;
         if (mem_we) nwe++;
         if (cpu_ack || dma_ack) got = 1'b1;
         else if (busy) gaddr = mem_addr;
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      e = sb.pop_front();
      rd = e.dma ? dma_rdata : cpu_rdata;
      checks++;
      if (!got) begin errors++; $display("FAIL %s ack: none within %0d cycles", nm, cyc); end
      checks++;
      if (cyc != 2) begin errors++; $display("FAIL %s latency: got %0d want 2", nm, cyc); end
      checks++;
      if ({dma_ack, cpu_ack} !== {e.dma, !e.dma}) begin
         errors++; $display("FAIL %s ack_src: got dma=%b cpu=%b want dma=%b", nm, dma_ack, cpu_ack, e.dma);
      end
      checks++;
      if (dma_err !== e.err) begin errors++; $display("FAIL %s dma_err: got %b want %b", nm, dma_err, e.err); end
      checks++;
      if (rd !== e.rdata) begin errors++; $display("FAIL %s rdata: got %h want %h", nm, rd, e.rdata); end
      checks++;
      if (nwe != ((we && !exp_err) ? 1 : 0)) begin
         errors++; $display("FAIL %s mem_we_pulses: got %0d want %0d", nm, nwe, (we && !exp_err) ? 1 : 0);
      end
      checks++;
      if (gaddr !== addr) begin errors++; $display("FAIL %s mem_addr: got %h want %h", nm, gaddr, addr); end
      @(posedge clock); #1;
      checks++;
      if ({cpu_ack, dma_ack, busy} !== 3'b000) begin
         errors++; $display("FAIL %s idle_after: got ack/ack/busy=%b want 000", nm, {cpu_ack, dma_ack, busy});
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({busy, cpu_ack, dma_ack, dma_err, mem_we} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {busy, cpu_ack, dma_ack, dma_err, mem_we});
      end
      checks++;
      if (cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin
         errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dma_rdata);
      end
      checks++;
      if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         errors++; $display("FAIL reset_memport: got %h/%h want 0/0", mem_addr, mem_wdata);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy got %b want 0", busy); end
   endtask

   task automatic test_cpu_write_read();
      do_access(1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 1'b0, 32'h0, "cpu_wr_04");
      do_access(1'b0, 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEADBEEF, "cpu_rd_04");
      do_access(1'b0, 1'b1, 32'h0C, 32'h0BADF00D, 1'b0, 32'hDEADBEEF, "cpu_wr_keeps_rdata");
   endtask

   task automatic test_dma_io();
      do_access(1'b0, 1'b1, 32'h80, 32'h55AA55AA, 1'b0, 32'hDEADBEEF, "cpu_wr_io");
      do_access(1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEADBEEF, "dma_rd_04");
      do_access(1'b1, 1'b1, 32'h80, 32'h11111111, 1'b1, 32'hDEADBEEF, "dma_wr_io");
      do_access(1'b1, 1'b0, 32'h84, 32'h0, 1'b1, 32'hDEADBEEF, "dma_rd_io");
      do_access(1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 32'h55AA55AA, "cpu_rd_io_unchanged");
      do_access(1'b1, 1'b1, 32'h08, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, "dma_wr_08");
      do_access(1'b0, 1'b0, 32'h08, 32'h0, 1'b0, 32'hCAFEF00D, "cpu_rd_08");
   endtask

   task automatic test_reset_in_gnt();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0C; cpu_wdata = 32'h12345678;
      @(posedge clock); #1;
      checks++;
      if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_gnt_pre: mem_we got %b want 1", mem_we); end
      reset = 1'b1;
      #1;
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_gnt_we: mem_we got %b want 0", mem_we); end
      @(posedge clock); #1;
      checks++;
      if ({cpu_ack, busy} !== 2'b00) begin
         errors++; $display("FAIL rst_gnt_state: ack/busy got %b want 00", {cpu_ack, busy});
      end
      reset = 1'b0; cpu_req = 1'b0;
      @(posedge clock); #1;
      do_access(1'b0, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0BADF00D, "rst_gnt_no_write");
   endtask

   task automatic test_arbitration();
      int  n, cyc, nack;
      bit  exp_dma;
      pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
      n = 12;
      gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
`else
      n = 18;
      repeat (4) gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
      gnt_q.push_back(1'b0);
`endif
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA0A0A0A0;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h24; dma_wdata = 32'hB0B0B0B0;
      nack = 0;
      for (cyc = 0; cyc < n; cyc++) begin
         @(posedge clock); #1;
         if (cpu_ack || dma_ack) begin
            nack++;
            exp_dma = (gnt_q.size() > 0) ? gnt_q.pop_front() : 1'b0;
            checks++;
            if ({dma_ack, cpu_ack} !== {exp_dma, !exp_dma} || dma_err !== 1'b0) begin
               errors++;
               $display("FAIL arb_grant%0d: got dma=%b cpu=%b err=%b want dma=%b err=0",
                        nack, dma_ack, cpu_ack, dma_err, exp_dma);
            end
         end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (nack != n / 3 || gnt_q.size() != 0) begin
         errors++; $display("FAIL arb_count: got %0d acks want %0d", nack, n / 3);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle: busy got %b want 0", busy); end
      gnt_q.delete();
   endtask

   initial begin
      test_reset();
      test_cpu_write_read();
      test_dma_io();
      test_reset_in_gnt();
      test_arbitration();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sc_dmem_arbiter.md
SC_DMEM_ARBITER -- requirements
Module: sc_dmem_arbiter

Interface
REQ-001 SHALL have parameter IO_BIT, default 7: address bit selecting the I/O region (1 = I/O, 0 = RAM).
REQ-002 SHALL have parameter STARVE_MAX, default 4: maximum consecutive DMA losses before DMA is forced to win.
REQ-003 SHALL have port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port `cpu_req`, input, 1 bit: CPU access request; held until `cpu_ack`.
REQ-006 SHALL have port `cpu_we`, input, 1 bit: CPU write (1) or read (0).
REQ-007 SHALL have ports `cpu_addr` and `cpu_wdata`, input, 32 bits each: CPU byte address and write data.
REQ-008 SHALL have port `cpu_rdata`, output, 32 bits: CPU read data, registered.
REQ-009 SHALL have port `cpu_ack`, output, 1 bit: one-cycle CPU completion pulse.
REQ-010 SHALL have ports `dma_req` (input 1), `dma_we` (input 1), `dma_addr` (input 32), `dma_wdata` (input 32): DMA request, same semantics as the CPU port.
REQ-011 SHALL have ports `dma_rdata` (output 32), `dma_ack` (output 1) and `dma_err` (output 1): DMA read data, completion pulse, and access-error flag.
REQ-012 SHALL have ports `mem_addr` (output 32), `mem_wdata` (output 32) and `mem_we` (output 1): the shared data-memory/I-O port.
REQ-013 SHALL have port `mem_rdata`, input, 32 bits: combinational read data from the data memory / I-O mux.
REQ-014 SHALL have port `busy`, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, GNT_CPU, GNT_DMA and DONE.
REQ-016 SHALL, in IDLE, go to GNT_CPU or GNT_DMA according to the arbitration rule; with no request it SHALL stay in IDLE.
REQ-017 SHALL go from either GNT state to DONE, and from DONE to IDLE, unconditionally.
REQ-018 SHALL, in GNT_x, drive `mem_addr` and `mem_wdata` from requester x's live inputs and assert `mem_we` = x_we for exactly that one cycle; outside GNT states `mem_we` SHALL be 0 and `mem_addr`/`mem_wdata` SHALL be 0.
REQ-019 SHALL capture `mem_rdata` into x_rdata at the end of GNT_x and assert x_ack throughout DONE, for exactly one cycle.
REQ-020 SHALL give a latency of 2 cycles from the req-sampling IDLE edge to ack and a throughput of 1 access per 3 cycles; the requester SHALL deassert req or present a new request on the edge where ack is seen.
REQ-021 SHALL hold x_rdata until the next completed read by requester x; writes SHALL leave x_rdata unchanged.
REQ-022 SHALL treat a DMA access with `dma_addr[IO_BIT]`=1 as illegal: GNT_DMA with `mem_we`=0 and x_rdata unchanged, and `dma_err`=1 alongside `dma_ack` in DONE; the CPU may access I/O freely.
REQ-023 SHALL keep a 3-bit starvation counter: increment on each CPU grant while `dma_req`=1 (saturating at 7), clear on each DMA grant; when counter >= STARVE_MAX and `dma_req`=1, DMA SHALL win regardless of the arbitration rule.
REQ-024 SHALL ignore req changes outside IDLE; a request dropped before grant is simply not served.

Reset
REQ-025 SHALL, on `reset`=1 at a clock edge, set state to IDLE, starvation counter to 0, last-grant to CPU, all acks/`dma_err`/`busy` to 0, and `cpu_rdata`/`dma_rdata` to 0.
REQ-026 SHALL force `mem_we`=0 combinationally while `reset`=1, so that reset asserted during a GNT cycle commits no write; an ack pending in DONE SHALL be lost.

Configuration
REQ-027 SHALL, with ARB_ROUND_ROBIN_EN defined, resolve simultaneous requests by granting the requester not granted last (last-grant register updated on every grant), with CPU first after reset.
REQ-028 SHALL, with ARB_ROUND_ROBIN_EN undefined, use fixed CPU priority, with the starvation override of REQ-023 still active.

Verification
REQ-029 SHALL cover: after reset, CPU write addr 0x04 data 0xDEADBEEF -> `mem_we`=1 for one cycle with `mem_addr`=0x04, `cpu_ack` 2 cycles after request; a following CPU read of 0x04 -> `cpu_rdata`=0xDEADBEEF.
REQ-030 SHALL cover: DMA write addr 0x80 -> `mem_we` stays 0, `dma_ack`=`dma_err`=1 for one cycle, memory unchanged.
REQ-031 SHALL cover: `cpu_req` and `dma_req` held high for 12 cycles with round-robin on -> grants alternate CPU, DMA, CPU, DMA, 4 acks total.
REQ-032 SHALL cover: both requests held continuously with round-robin off -> 4 CPU grants, then 1 DMA grant (STARVE_MAX=4), then CPU again.
REQ-033 SHALL cover: `reset` asserted in the GNT_CPU cycle of a write -> `mem_we`=0, no ack, IDLE on the next cycle.
